// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl - time-multiplexed scan controller for a multi-digit
// seven-segment display. One shared decoder is steered across all digits. Each
// digit slot is BLANK_CYCLES of all-off blanking followed by REFRESH_DIV cycles
// of drive. New display values are double-buffered and are applied only at the
// frame boundary.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, leading
// zero digits above digit 0 are suppressed.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   digits_in  nibble k is the value for digit k (digit 0 is the rightmost digit)
//   load       captures digits_in into the shadow register
//   digit_en   per-digit enable, sampled live
//   Cathode    registered segment bus, 1 = segment on
//   Anode      registered active-low digit selects, at most one low
//   frame_done one-cycle pulse when the last digit's drive ends

module sseg_decoder (
    input  logic [3:0] val,
    output logic [7:0] seg
);
    // Bit order is {dp,g,f,e,d,c,b,a}. The dp segment is never lit.
    always_comb begin
        seg = 8'h00;
        case (val)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            4'hF: seg = 8'h71;
            default: seg = 8'h00;
        endcase
    end
endmodule

module sseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [7:0]              Cathode,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic                    frame_done
);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] DRV_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                       state, state_nxt;
    logic [CW-1:0]                cnt, cnt_nxt;
    logic [IW-1:0]                idx, idx_nxt;
    logic                         boundary;
    logic [NUM_DIGITS-1:0][3:0]   shadow, active;
    logic                         pending;
    logic [3:0]                   dec_in;
    logic [7:0]                   dec_out;
    logic [NUM_DIGITS-1:0]        lit;
    logic [NUM_DIGITS-1:0]        an_nxt;
    logic [7:0]                   cat_nxt;

`ifdef LEADING_ZERO_BLANK_EN
    // lz[k] is set when nibbles NUM_DIGITS-1 down to k are all zero.
    // Digit 0 is never suppressed.
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = (active[NUM_DIGITS-1] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--)
            lz[k] = lz[k+1] && (active[k] == 4'd0);
        lz[0] = 1'b0;
    end
    assign lit = digit_en & ~lz;
`else
    assign lit = digit_en;
`endif

    // Steer the shared decoder to the current digit. The index does not change
    // on BLANK->DRIVE, so the current idx is also the digit about to be driven.
    always_comb begin
        dec_in = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (IW'(k) == idx) dec_in = active[k];
    end

    sseg_decoder u_dec (
        .val (dec_in),
        .seg (dec_out)
    );

    // Next state, and output values for the next state, so each state's
    // outputs appear on the first edge of that state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        boundary  = 1'b0;
        case (state)
            BLANK: if (cnt == BLK_LAST) begin
                state_nxt = DRIVE;
                cnt_nxt   = '0;
            end
            DRIVE: if (cnt == DRV_LAST) begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
                idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                boundary  = (idx == IDX_LAST);
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase

        an_nxt  = '1;
        cat_nxt = 8'h00;
        if (state_nxt == DRIVE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (IW'(k) == idx && lit[k]) begin
                    an_nxt[k] = 1'b0;
                    cat_nxt   = dec_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            Anode      <= '1;
            Cathode    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            Anode      <= an_nxt;
            Cathode    <= cat_nxt;
            frame_done <= boundary;
        end
    end

    // Double buffer. If a load coincides with the boundary, the load bypasses
    // the shadow register and goes straight to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) shadow <= digits_in;
            if (boundary) begin
                if (load)         active <= digits_in;
                else if (pending) active <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end
endmodule
